// File: rtl/avalon_burst_sram_bridge.sv
// avalon_burst_sram_bridge: Avalon-MM burst slave that serialises each burst into single-word async SRAM accesses
module avalon_burst_sram_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 20,
  parameter int BURST_WIDTH     = 5,
  parameter int WAIT_CYCLES     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_WIDTH-1:0]      avalon_slave_address,
  input  logic [BURST_WIDTH-1:0]     avalon_slave_burstcount,
  input  logic                       avalon_slave_read,
  input  logic                       avalon_slave_write,
  input  logic [3:0]                 avalon_slave_byteenable,
  input  logic [31:0]                avalon_slave_writedata,
  output logic                       avalon_slave_waitrequest,
  output logic [31:0]                avalon_slave_readdata,
  output logic                       avalon_slave_readdatavalid,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]                sram_data_o,
  input  logic [31:0]                sram_data_i,
  output logic                       sram_data_oe,
  output logic                       sram_ce_n,
  output logic                       sram_oe_n,
  output logic                       sram_we_n,
  output logic [3:0]                 sram_be_n
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] RD_ACCESS = 3'd1;
  localparam logic [2:0] WR_SETUP  = 3'd2;
  localparam logic [2:0] WR_PULSE  = 3'd3;
  localparam logic [2:0] WR_NEXT   = 3'd4;
  logic [2:0]                 state_q, state_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BURST_WIDTH-1:0]     rem_q, rem_d, first_rem;
  logic [3:0]                 cnt_q, cnt_d, be_q, be_d;
  logic [31:0]                data_q, data_d, rdata_q, rdata_d;
  logic                       rdv_q, rdv_d, last, rd, wr, unused;
  assign unused    = ^avalon_slave_address;
  assign first_rem = (avalon_slave_burstcount == '0) ? '0 : avalon_slave_burstcount - 1'b1;
  assign last      = cnt_q == 4'(WAIT_CYCLES);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    rdv_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (avalon_slave_write || avalon_slave_read) begin
          state_d = avalon_slave_write ? WR_SETUP : RD_ACCESS;
          addr_d  = avalon_slave_address[SRAM_ADDR_WIDTH+1:2];
          rem_d   = first_rem;
          data_d  = avalon_slave_write ? avalon_slave_writedata : data_q;
          be_d    = avalon_slave_write ? avalon_slave_byteenable : be_q;
        end
      end
      RD_ACCESS: begin
        cnt_d = last ? '0 : cnt_q + 4'd1;
        if (last) begin
          rdata_d = sram_data_i;
          rdv_d   = 1'b1;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == '0) ? IDLE : RD_ACCESS;
        end
      end
      WR_SETUP: begin
        cnt_d   = '0;
        state_d = WR_PULSE;
      end
      WR_PULSE: begin
        cnt_d   = last ? '0 : cnt_q + 4'd1;
        state_d = !last ? WR_PULSE : (rem_q == '0) ? IDLE : WR_NEXT;
      end
      WR_NEXT: begin
        if (avalon_slave_write) begin
          data_d  = avalon_slave_writedata;
          be_d    = avalon_slave_byteenable;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = WR_SETUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      rdv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      rdv_q   <= rdv_d;
    end
  end
  // strobes decode straight from state so an async reset releases the SRAM bus at once
  assign rd                         = state_q == RD_ACCESS;
  assign wr                         = (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_NEXT);
  assign avalon_slave_waitrequest   = !((state_q == IDLE) || ((state_q == WR_NEXT) && avalon_slave_write));
  assign avalon_slave_readdata      = rdata_q;
  assign avalon_slave_readdatavalid = rdv_q;
  assign sram_addr                  = addr_q;
  assign sram_data_o                = data_q;
  assign sram_data_oe               = wr;
  assign sram_ce_n                  = !(rd || wr);
  assign sram_oe_n                  = !rd;
  assign sram_we_n                  = state_q != WR_PULSE;
  assign sram_be_n                  = rd ? 4'h0 : wr ? ~be_q : 4'hF;
endmodule

// File: tb/tb_avalon_burst_sram_bridge.sv
// tb_avalon_burst_sram_bridge: directed stimulus with queue-based scoreboard and SRAM-side monitor
module tb_avalon_burst_sram_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] avalon_slave_address = '0;
  logic [4:0]  avalon_slave_burstcount = '0;
  logic        avalon_slave_read = 1'b0;
  logic        avalon_slave_write = 1'b0;
  logic [3:0]  avalon_slave_byteenable = '0;
  logic [31:0] avalon_slave_writedata = '0;
  logic        avalon_slave_waitrequest;
  logic [31:0] avalon_slave_readdata;
  logic        avalon_slave_readdatavalid;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_o, sram_data_i;
  logic        sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [3:0]  sram_be_n;
  logic [31:0] mem [32];
  logic [19:0] aq [$];
  logic [63:0] rq [$];
  logic [55:0] wq [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_acc = 0;
  avalon_burst_sram_bridge #(
    .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(20), .BURST_WIDTH(5), .WAIT_CYCLES(1)
  ) dut (
    .clk(clk), .rst(rst),
    .avalon_slave_address(avalon_slave_address),
    .avalon_slave_burstcount(avalon_slave_burstcount),
    .avalon_slave_read(avalon_slave_read),
    .avalon_slave_write(avalon_slave_write),
    .avalon_slave_byteenable(avalon_slave_byteenable),
    .avalon_slave_writedata(avalon_slave_writedata),
    .avalon_slave_waitrequest(avalon_slave_waitrequest),
    .avalon_slave_readdata(avalon_slave_readdata),
    .avalon_slave_readdatavalid(avalon_slave_readdatavalid),
    .sram_addr(sram_addr),
    .sram_data_o(sram_data_o),
    .sram_data_i(sram_data_i),
    .sram_data_oe(sram_data_oe),
    .sram_ce_n(sram_ce_n),
    .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign sram_data_i = mem[sram_addr[4:0]];
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask
  task automatic issue(input logic wr, input logic [31:0] a, input logic [4:0] bc, input logic [31:0] d, input logic [3:0] be);
    int n = 0;
    @(negedge clk);
    avalon_slave_address = a;
    avalon_slave_burstcount = bc;
    avalon_slave_writedata = d;
    avalon_slave_byteenable = be;
    avalon_slave_read = !wr;
    avalon_slave_write = wr;
    #1;
    while (avalon_slave_waitrequest && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("cmd_accept", {63'd0, avalon_slave_waitrequest}, 64'd0);
    last_acc = cyc;
    @(posedge clk);
    #1;
    avalon_slave_read = 1'b0;
    avalon_slave_write = 1'b0;
  endtask
  task automatic wbeat(input logic [31:0] d, input logic [3:0] be, input int gap);
    int n = 0;
    do begin @(negedge clk); n++; end while (sram_we_n && n < 20);
    do begin @(negedge clk); n++; end while (!sram_we_n && n < 40);
    chk("reach_wr_next", {61'd0, sram_we_n, sram_ce_n, sram_data_oe}, 64'b101);
    for (int i = 0; i < gap; i++) begin
      chk("gap_stall", {62'd0, avalon_slave_waitrequest, sram_we_n}, 64'b11);
      @(negedge clk);
    end
    avalon_slave_writedata = d;
    avalon_slave_byteenable = be;
    avalon_slave_write = 1'b1;
    #1;
    chk("next_accept", {63'd0, avalon_slave_waitrequest}, 64'd0);
    @(posedge clk);
    #1;
    avalon_slave_write = 1'b0;
  endtask
  // SRAM model plus monitor: pops expectations whenever the DUT presents a beat or an access
  initial begin
    logic        p_we, p_oe, p_ce, p_doe;
    logic [19:0] p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_be;
    logic [55:0] wcap, wexp;
    logic [63:0] rexp;
    int          rlen, wlen;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[3] = 32'h12345678;
    mem[8] = 32'hCAFE0008; mem[9] = 32'hCAFE0009; mem[10] = 32'hCAFE000A; mem[11] = 32'hCAFE000B;
    mem[16] = 32'h11223344;
    mem[31] = 32'h0BADF00F;
    mem[0] = 32'h00000A0A;
    p_we = 1; p_oe = 1; p_ce = 1; p_doe = 0; p_addr = '0; p_data = '0; p_be = 4'hF;
    wcap = '0; rlen = 0; wlen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aq.delete(); rq.delete(); wq.delete();
        p_we = 1; p_oe = 1; rlen = 0; wlen = 0;
      end else begin
        if (!sram_oe_n)
          chk("rd_drive", {59'd0, sram_data_oe, avalon_slave_waitrequest, sram_ce_n, sram_be_n == 4'h0, sram_we_n}, 64'b01011);
        if (!sram_oe_n && (p_oe || sram_addr != p_addr)) begin
          if (!p_oe) chk("rd_hold_len", 64'(rlen), 64'd2);
          if (aq.size() == 0) chk("rd_addr_extra", 64'(aq.size()), 64'd1);
          else chk("rd_addr", {44'd0, sram_addr}, {44'd0, aq.pop_front()});
          rlen = 1;
        end else if (!sram_oe_n) rlen++;
        else if (!p_oe) chk("rd_hold_len", 64'(rlen), 64'd2);
        if (!sram_we_n && p_we) begin
          wcap = {sram_addr, sram_data_o, sram_be_n};
          if (wq.size() == 0) chk("wr_extra", 64'(wq.size()), 64'd1);
          else begin
            wexp = wq.pop_front();
            chk("wr_beat", {8'd0, wcap}, {8'd0, wexp});
          end
          chk("wr_setup", {58'd0, p_ce, p_doe, p_we, p_addr == sram_addr, p_data == sram_data_o, p_be == sram_be_n}, 64'b011111);
          chk("wr_strobes", {61'd0, sram_ce_n, sram_oe_n, sram_data_oe}, 64'b011);
          for (int b = 0; b < 4; b++) if (!sram_be_n[b]) mem[sram_addr[4:0]][8*b +: 8] = sram_data_o[8*b +: 8];
          wlen = 1;
        end else if (!sram_we_n) begin
          chk("wr_hold", {8'd0, sram_addr, sram_data_o, sram_be_n}, {8'd0, wcap});
          wlen++;
        end else if (!p_we) chk("wr_pulse_len", 64'(wlen), 64'd2);
        if (avalon_slave_readdatavalid) begin
          if (rq.size() == 0) chk("rdv_extra", 64'(rq.size()), 64'd1);
          else begin
            rexp = rq.pop_front();
            chk("rd_data", {32'd0, avalon_slave_readdata}, {32'd0, rexp[63:32]});
            chk("rd_latency", 64'(cyc - last_acc), {32'd0, rexp[31:0]});
          end
        end
        p_we = sram_we_n; p_oe = sram_oe_n; p_ce = sram_ce_n; p_doe = sram_data_oe;
        p_addr = sram_addr; p_data = sram_data_o; p_be = sram_be_n;
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_strobes", {57'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe, avalon_slave_readdatavalid, avalon_slave_waitrequest, 1'b0}, 64'b1110000);
    chk("rst_bus", {sram_be_n, sram_addr, 8'd0, sram_data_o}, {4'hF, 60'd0});
    chk("rst_rdata", {32'd0, avalon_slave_readdata}, 64'd0);
    #1 rst = 1'b0;
    // single read of word 3
    aq.push_back(20'h3);
    rq.push_back({32'h12345678, 32'd3});
    issue(1'b0, 32'h0C, 5'd1, 32'h0, 4'h0);
    // 4-beat line fill from word 8
    for (int i = 0; i < 4; i++) aq.push_back(20'h8 + 20'(i));
    rq.push_back({32'hCAFE0008, 32'd3});
    rq.push_back({32'hCAFE0009, 32'd5});
    rq.push_back({32'hCAFE000A, 32'd7});
    rq.push_back({32'hCAFE000B, 32'd9});
    issue(1'b0, 32'h20, 5'd4, 32'h0, 4'h0);
    // 4-beat write-back at word 5, second beat held off by the master for 3 cycles
    for (int i = 0; i < 4; i++) wq.push_back({20'h5 + 20'(i), 32'hDEADBEEF + 32'(i), 4'h0});
    issue(1'b1, 32'h14, 5'd4, 32'hDEADBEEF, 4'hF);
    wbeat(32'hDEADBEF0, 4'hF, 3);
    wbeat(32'hDEADBEF1, 4'hF, 0);
    wbeat(32'hDEADBEF2, 4'hF, 1);
    // partial byte-lane write then read-back of the merged word
    wq.push_back({20'h10, 32'hAABBCCDD, 4'b1010});
    issue(1'b1, 32'h40, 5'd1, 32'hAABBCCDD, 4'b0101);
    aq.push_back(20'h10);
    rq.push_back({32'h11BB33DD, 32'd3});
    issue(1'b0, 32'h40, 5'd1, 32'h0, 4'h0);
    // word address wraps past the top of the SRAM
    aq.push_back(20'hFFFFF);
    aq.push_back(20'h00000);
    rq.push_back({32'h0BADF00F, 32'd3});
    rq.push_back({32'h00000A0A, 32'd5});
    issue(1'b0, 32'h003FFFFC, 5'd2, 32'h0, 4'h0);
    // reset during the second beat's write pulse
    wq.push_back({20'h72, 32'h51000001, 4'h0});
    wq.push_back({20'h73, 32'h51000002, 4'h0});
    issue(1'b1, 32'h1C8, 5'd4, 32'h51000001, 4'hF);
    wbeat(32'h51000002, 4'hF, 0);
    @(posedge clk);
    #1;
    chk("pulse_before_rst", {63'd0, sram_we_n}, 64'd0);
    rst = 1'b1;
    #1;
    chk("async_rst", {61'd0, sram_we_n, sram_ce_n, sram_data_oe}, 64'b110);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_idle", {62'd0, avalon_slave_waitrequest, avalon_slave_readdatavalid}, 64'd0);
    // burstcount 0 behaves as a single beat
    aq.push_back(20'h3);
    rq.push_back({32'h12345678, 32'd3});
    issue(1'b0, 32'h0C, 5'd0, 32'h0, 4'h0);
    repeat (12) @(negedge clk);
    chk("rd_pending", 64'(rq.size()), 64'd0);
    chk("addr_pending", 64'(aq.size()), 64'd0);
    chk("wr_pending", 64'(wq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/avalon_burst_sram_bridge.md
Name: avalon_burst_sram_bridge

Overview:
Avalon-MM burst slave that sits directly downstream of the cache's burst master port and serves cache line fills and write-backs. It converts each burst into a sequence of single-word accesses on the board's 32-bit asynchronous SRAM. Each SRAM access uses a programmable wait-state count.

Parameters:
ADDR_WIDTH, 32, Avalon byte-address width
SRAM_ADDR_WIDTH, 20, SRAM word-address width
BURST_WIDTH, 5, burstcount width (max burst 2^BURST_WIDTH-1 beats)
WAIT_CYCLES, 1, extra cycles per SRAM access beyond the first (0..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
avalon_slave_address  in  ADDR_WIDTH  byte address, sampled on command accept
avalon_slave_burstcount  in  BURST_WIDTH  beats in burst; 0 treated as 1
avalon_slave_read  in  1  read command
avalon_slave_write  in  1  write command / write beat
avalon_slave_byteenable  in  4  byte lanes for write beat
avalon_slave_writedata  in  32  write beat data
avalon_slave_waitrequest  out  1  stall
avalon_slave_readdata  out  32  read beat data (registered)
avalon_slave_readdatavalid  out  1  one-cycle pulse per read beat
sram_addr  out  SRAM_ADDR_WIDTH  word address
sram_data_o  out  32  write data
sram_data_i  in  32  read data
sram_data_oe  out  1  tri-state enable for sram_data_o
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
sram_be_n  out  4  byte enables, active low

Behaviour:
- Reset (async, immediate): state=IDLE. sram_ce_n/oe_n/we_n=1, sram_be_n=4'hF, sram_data_oe=0, sram_addr=0, sram_data_o=0. readdatavalid=0, readdata=0. Any in-flight burst is dropped.
- Word address = avalon_slave_address[SRAM_ADDR_WIDTH+1:2]; bits [1:0] are ignored. Increments by 1 per beat and wraps modulo 2^SRAM_ADDR_WIDTH.
- waitrequest is 0 only in IDLE, or in WR_NEXT while write=1. It is 1 everywhere else.
- States: IDLE, RD_ACCESS, WR_SETUP, WR_PULSE, WR_NEXT.
- IDLE:
  - write=1 wins over read=1.
  - On write: latch address, burstcount, writedata, byteenable; remaining=count-1; go to WR_SETUP.
  - On read: latch address, count; go to RD_ACCESS.
- RD_ACCESS:
  - Outputs: ce_n=0, oe_n=0, be_n=0, data_oe=0.
  - Holds each address for WAIT_CYCLES+1 cycles.
  - On the last cycle's edge: capture sram_data_i into readdata and pulse readdatavalid in the next cycle; advance address.
  - After the final beat's capture, go to IDLE. The final readdatavalid coincides with IDLE, so a new command may be accepted in that same cycle.
  - Read timing: first readdatavalid occurs WAIT_CYCLES+2 cycles after the accepting edge; subsequent beats follow every WAIT_CYCLES+1 cycles.
- WR_SETUP (1 cycle):
  - Outputs: ce_n=0, we_n=1, data_oe=1, be_n=~byteenable, sram_data_o=latched data.
  - Go to WR_PULSE.
- WR_PULSE (WAIT_CYCLES+1 cycles):
  - Outputs: we_n=0; address, data and be_n held.
  - On exit: go to IDLE if remaining=0, else WR_NEXT.
- WR_NEXT:
  - Outputs: we_n=1, ce_n=0, data_oe=1; address and data still held (hold time).
  - On write=1 (accepted this cycle): latch data and byteenable, advance address, decrement remaining, go to WR_SETUP.
  - read=1 in WR_NEXT is a protocol violation: ignored, waitrequest stays 1 unless write=1.
- Write cost: WAIT_CYCLES+2 cycles per beat, plus at least 1 WR_NEXT cycle between beats.
- data_oe is 1 only in WR_SETUP/WR_PULSE/WR_NEXT. oe_n and data_oe are never both active.

Test Plan:
- Single read, W=1, sram returns 32'h12345678 at word 0x3: read addr 0x0C, count 1 → waitrequest 0 at accept; sram_addr=0x3, oe_n=0 for 2 cycles; readdatavalid high 3 cycles after accept with readdata=32'h12345678; back in IDLE.
- 4-beat read at 0x20 (cache line fill) → sram_addr 0x8,0x9,0xA,0xB, 2 cycles each; 4 readdatavalid pulses spaced 2 cycles apart with the matching data; waitrequest 1 until last beat.
- 4-beat write at 0x14, data DEADBEEF..+3, byteenable F → each beat gives 1 setup cycle + 2 we_n-low cycles at words 0x5..0x8. A second beat delayed 3 cycles by the master keeps we_n=1 and waitrequest=1 during the gap.
- Byte-lane write: byteenable 4'b0101, data 32'hAABBCCDD at 0x40 → sram_be_n=4'b1010 throughout SETUP/PULSE; a following read returns be_n=0.
- Wrap: SRAM_ADDR_WIDTH=4, 2-beat read at byte 0x3C → sram_addr 0xF then 0x0.
- Reset mid-write (rst asserted during WR_PULSE, beat 2 of 4) → we_n, ce_n go 1 and data_oe goes 0 without waiting for clk; after release the bridge is in IDLE with waitrequest 0, and a new read completes normally.
